dpi_stream_sequencer: RTL and testbench



---
 rtl/dpi_stream_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// Flow-key to stream-id mapper and matcher control sequencer (load_state -> chars -> eop).
// Define STREAM_SEQ_STATS_EN to add packet/allocation/eviction counters.
module dpi_stream_sequencer #(
    parameter int SID_W    = 6,
    parameter int KEY_W    = 32,
    parameter int LOAD_GAP = 3,
    parameter int EOP_GAP  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hdr_vld,
    output logic                   hdr_rdy,
    input  logic [KEY_W-1:0]       hdr_key,
    input  logic                   hdr_empty,
    input  logic                   pl_vld,
    output logic                   pl_rdy,
    input  logic [7:0]             pl_data,
    input  logic                   pl_last,
    input  logic [2**SID_W-1:0]    cfg_enable_mask,
    input  logic                   table_clear,
    output logic                   load_state,
    output logic [SID_W-1:0]       stream_id,
    output logic                   new_stream_id,
    output logic                   enable,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
`ifdef STREAM_SEQ_STATS_EN
    output logic [15:0]            stat_pkts,
    output logic [15:0]            stat_new,
    output logic [15:0]            stat_evict,
`endif
    output logic                   eop
);

    localparam int NUM_STREAMS = 2**SID_W;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP} state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [KEY_W-1:0]       key_r;
    logic                   empty_r;
    logic [NUM_STREAMS-1:0] valid_r;
    logic [KEY_W-1:0]       keys_r [NUM_STREAMS];
    logic [SID_W-1:0]       victim_r;
    logic                   clear_pend_r;
    logic                   hit_s, free_s;
    logic [SID_W-1:0]       hit_idx_s, free_idx_s, sel_idx_s;
    logic                   hdr_hs_s, pl_hs_s;

    assign hdr_hs_s = hdr_vld & hdr_rdy;
    assign pl_hs_s  = pl_vld & pl_rdy;

    // Fully-associative search; descending scan leaves the lowest free index.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        free_s     = 1'b0;
        free_idx_s = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (valid_r[i] && (keys_r[i] == key_r)) begin
                hit_s     = 1'b1;
                hit_idx_s = SID_W'(i);
            end else if (!valid_r[i]) begin
                free_s     = 1'b1;
                free_idx_s = SID_W'(i);
            end else begin
            end
        end
        sel_idx_s = hit_s ? hit_idx_s : (free_s ? free_idx_s : victim_r);
    end

    // Next-state logic. Gap counts absorb the one-cycle char output register so
    // that idle cycles are exact at the matcher interface.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (hdr_hs_s) state_s = LOOKUP;
                else          state_s = IDLE;
            end
            LOOKUP: state_s = LOAD;
            LOAD: begin
                state_s = GAP;
                cnt_s   = CNT_W'(LOAD_GAP - 1);
            end
            GAP: begin
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r <= CNT_W'(1)) begin
                    if (empty_r) begin
                        state_s = DRAIN;
                        cnt_s   = CNT_W'(EOP_GAP + 2);
                    end else begin
                        state_s = STREAM;
                    end
                end else begin
                    state_s = GAP;
                end
            end
            STREAM: begin
                if (pl_hs_s && pl_last) begin
                    state_s = DRAIN;
                    cnt_s   = CNT_W'(EOP_GAP + 1);
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r <= CNT_W'(1)) state_s = EOP;
                else                    state_s = DRAIN;
            end
            EOP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and gap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered handshake and matcher control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_rdy     <= 1'b0;
            pl_rdy      <= 1'b0;
            load_state  <= 1'b0;
            eop         <= 1'b0;
            char_in     <= 8'h00;
            char_in_vld <= 1'b0;
            key_r       <= '0;
            empty_r     <= 1'b0;
        end else begin
            hdr_rdy     <= (state_s == IDLE);
            pl_rdy      <= (state_s == STREAM);
            load_state  <= (state_s == LOAD);
            eop         <= (state_s == EOP);
            char_in_vld <= pl_hs_s;
            if (pl_hs_s) char_in <= pl_data;
            if (hdr_hs_s) begin
                key_r   <= hdr_key;
                empty_r <= hdr_empty;
            end
        end
    end

    // Table valid bits, victim pointer, deferred clear and per-packet stream context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r       <= '0;
            victim_r      <= '0;
            clear_pend_r  <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= 1'b0;
        end else if (state_r == IDLE) begin
            clear_pend_r <= 1'b0;
            if (table_clear || clear_pend_r) valid_r <= '0;
        end else begin
            if (table_clear) clear_pend_r <= 1'b1;
            if (state_r == LOOKUP) begin
                valid_r[sel_idx_s] <= 1'b1;
                stream_id          <= sel_idx_s;
                new_stream_id      <= ~hit_s;
                enable             <= cfg_enable_mask[sel_idx_s];
                if (!hit_s && !free_s) victim_r <= victim_r + SID_W'(1);
            end
        end
    end

    // Key storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if ((state_r == LOOKUP) && !hit_s) keys_r[sel_idx_s] <= key_r;
    end

`ifdef STREAM_SEQ_STATS_EN
    // Event counters, wrapping at 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkts  <= 16'h0000;
            stat_new   <= 16'h0000;
            stat_evict <= 16'h0000;
        end else begin
            if (state_s == EOP) stat_pkts <= stat_pkts + 16'h0001;
            if ((state_r == LOOKUP) && !hit_s) begin
                stat_new <= stat_new + 16'h0001;
                if (!free_s) stat_evict <= stat_evict + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: table hit/miss/evict, gap timing, enable freeze, clear.
module tb_dpi_stream_sequencer;

    localparam int NS = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          hdr_vld, hdr_rdy, hdr_empty;
    logic [31:0]   hdr_key;
    logic          pl_vld, pl_rdy, pl_last;
    logic [7:0]    pl_data;
    logic [NS-1:0] cfg_enable_mask;
    logic          table_clear;
    logic          load_state, new_stream_id, enable, char_in_vld, eop;
    logic [5:0]    stream_id;
    logic [7:0]    char_in;
`ifdef STREAM_SEQ_STATS_EN
    logic [15:0]   stat_pkts, stat_new, stat_evict;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_pkts = 0;
    int exp_alloc = 0;

    always #5 clk = ~clk;

    dpi_stream_sequencer dut (
        .clk(clk), .rst(rst),
        .hdr_vld(hdr_vld), .hdr_rdy(hdr_rdy), .hdr_key(hdr_key), .hdr_empty(hdr_empty),
        .pl_vld(pl_vld), .pl_rdy(pl_rdy), .pl_data(pl_data), .pl_last(pl_last),
        .cfg_enable_mask(cfg_enable_mask), .table_clear(table_clear),
        .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld),
`ifdef STREAM_SEQ_STATS_EN
        .stat_pkts(stat_pkts), .stat_new(stat_new), .stat_evict(stat_evict),
`endif
        .eop(eop)
    );

    // Output monitor, sampled on the falling edge.
    int         cyc = 0, load_cyc = 0, eop_cyc = 0, load_cnt = 0, eop_cnt = 0, nchar = 0;
    logic [5:0] ld_sid, eop_sid;
    logic       ld_new, ld_en, eop_en;
    logic [7:0] chars [256];
    int         char_cyc [256];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (load_state) begin
            load_cyc <= cyc;
            load_cnt <= load_cnt + 1;
            ld_sid   <= stream_id;
            ld_new   <= new_stream_id;
            ld_en    <= enable;
        end
        if (char_in_vld && nchar < 256) begin
            chars[nchar]    <= char_in;
            char_cyc[nchar] <= cyc;
            nchar           <= nchar + 1;
        end
        if (eop) begin
            eop_cyc <= cyc;
            eop_cnt <= eop_cnt + 1;
            eop_sid <= stream_id;
            eop_en  <= enable;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // clr: 0 none, 1 pulse during first payload byte, 2 together with header handshake.
    task automatic send_pkt(input string tag, input logic [31:0] key, input bit empty, input int n,
                            input bit toggle, input int clr, input bit flip,
                            input logic [5:0] exp_sid, input bit exp_new, input bit exp_en);
        bit         got;
        int         l0, e0, n0;
        logic [7:0] seed;
        seed = key[7:0] ^ 8'h5A;
        l0 = load_cnt; e0 = eop_cnt; n0 = nchar;
        exp_pkts++;
        if (exp_new) exp_alloc++;
        hdr_vld = 1'b1; hdr_key = key; hdr_empty = empty; table_clear = (clr == 2);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk); got = hdr_rdy;
            @(posedge clk); #1;
        end
        check({tag, "/hdr_acc"}, 32'(got), 32'd1);
        hdr_vld = 1'b0; table_clear = 1'b0;
        for (int i = 0; i < n; i++) begin
            pl_vld = 1'b1; pl_data = seed + 8'(i); pl_last = (i == n - 1);
            table_clear = (clr == 1) && (i == 0);
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                @(negedge clk); got = pl_rdy;
                @(posedge clk); #1;
            end
            check({tag, "/pl_acc"}, 32'(got), 32'd1);
            pl_vld = 1'b0; pl_last = 1'b0; table_clear = 1'b0;
            if (flip && i == 0) cfg_enable_mask[2] = ~cfg_enable_mask[2];
            if (toggle && i < n - 1) begin @(posedge clk); #1; end
        end
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(posedge clk); #1; got = (eop_cnt != e0);
        end
        check({tag, "/eop_seen"}, 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "/load_once"}, 32'(load_cnt - l0), 32'd1);
        check({tag, "/eop_once"}, 32'(eop_cnt - e0), 32'd1);
        check({tag, "/sid"}, 32'(ld_sid), 32'(exp_sid));
        check({tag, "/new"}, 32'(ld_new), 32'(exp_new));
        check({tag, "/en"}, 32'(ld_en), 32'(exp_en));
        check({tag, "/sid_eop"}, 32'(eop_sid), 32'(exp_sid));
        check({tag, "/en_eop"}, 32'(eop_en), 32'(exp_en));
        check({tag, "/nchar"}, 32'(nchar - n0), 32'(n));
        for (int i = 0; i < n; i++)
            check({tag, $sformatf("/char%0d", i)}, 32'(chars[n0 + i]), 32'(seed + 8'(i)));
        if (empty) begin
            check({tag, "/eop_after_load"}, 32'(eop_cyc - load_cyc), 32'd8);
        end else begin
            check({tag, "/first_char"}, 32'(char_cyc[n0] - load_cyc), 32'd4);
            check({tag, "/eop_after_last"}, 32'(eop_cyc - char_cyc[n0 + n - 1]), 32'd4);
            if (toggle)
                for (int i = 0; i < n - 1; i++)
                    check({tag, $sformatf("/gap%0d", i)},
                          32'(char_cyc[n0 + i + 1] - char_cyc[n0 + i]), 32'd2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hdr_vld = 1'b1; hdr_key = 32'hA5A5_0001; hdr_empty = 1'b0;
        pl_vld = 1'b0; pl_data = 8'h00; pl_last = 1'b0; cfg_enable_mask = '1; table_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", 32'({hdr_rdy, pl_rdy, load_state, stream_id, new_stream_id, enable,
                               char_in, char_in_vld, eop}), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_rst", 32'(hdr_rdy), 32'd1);

        send_pkt("p1_new",    32'hA5A5_0001, 1'b0, 4, 1'b0, 0, 1'b0, 6'd0, 1'b1, 1'b1);
        send_pkt("p2_hit",    32'hA5A5_0001, 1'b0, 2, 1'b0, 0, 1'b0, 6'd0, 1'b0, 1'b1);
        send_pkt("p3_new",    32'hB000_0002, 1'b0, 3, 1'b0, 0, 1'b0, 6'd1, 1'b1, 1'b1);
        cfg_enable_mask[2] = 1'b0;
        send_pkt("p4_dis",    32'hC000_0003, 1'b0, 3, 1'b0, 0, 1'b1, 6'd2, 1'b1, 1'b0);
        send_pkt("p5_en",     32'hC000_0003, 1'b0, 2, 1'b0, 0, 1'b0, 6'd2, 1'b0, 1'b1);
        send_pkt("p6_empty",  32'hD000_0004, 1'b1, 0, 1'b0, 0, 1'b0, 6'd3, 1'b1, 1'b1);
        send_pkt("p7_toggle", 32'hA5A5_0001, 1'b0, 3, 1'b1, 0, 1'b0, 6'd0, 1'b0, 1'b1);

        for (int i = 4; i < NS; i++)
            send_pkt($sformatf("fill%0d", i), 32'h1000_0000 + 32'(i), 1'b0, 1, 1'b0, 0, 1'b0,
                     6'(i), 1'b1, 1'b1);

        send_pkt("ev65",      32'hE000_0065, 1'b0, 2, 1'b0, 0, 1'b0, 6'd0, 1'b1, 1'b1);
        send_pkt("ev66",      32'hE000_0066, 1'b0, 1, 1'b0, 0, 1'b0, 6'd1, 1'b1, 1'b1);
        send_pkt("ev_resend", 32'hA5A5_0001, 1'b0, 1, 1'b0, 0, 1'b0, 6'd2, 1'b1, 1'b1);

        send_pkt("clr_strm",  32'h1000_0010, 1'b0, 3, 1'b0, 1, 1'b0, 6'd16, 1'b0, 1'b1);
        send_pkt("post_clr",  32'h1000_0010, 1'b0, 2, 1'b0, 0, 1'b0, 6'd0, 1'b1, 1'b1);
        send_pkt("clr_hdr",   32'h1000_0010, 1'b0, 1, 1'b0, 2, 1'b0, 6'd0, 1'b1, 1'b1);

`ifdef STREAM_SEQ_STATS_EN
        check("stat_pkts",  32'(stat_pkts),  32'(exp_pkts));
        check("stat_new",   32'(stat_new),   32'(exp_alloc));
        check("stat_evict", 32'(stat_evict), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
